// File: rtl/seq_pkg.sv
// seq_pkg: shared constants and types for the SEQ Y-86 sequencing controller.
//   - icode constants IHALT..IPOPQ
//   - processor status codes (AOK/HLT/ADR/INS)
//   - controller state enum
package seq_pkg;

    // Y-86 instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Processor status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Controller states, one per datapath stage plus idle/terminal
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_STOP      = 3'd7
    } state_t;

endpackage

// File: rtl/seq_pc_select.sv
// pc_select: combinational next-PC mux for the SEQ processor.
//   icode  in  4   instruction code
//   cnd    in  1   branch condition from execute
//   valC   in  64  constant word (call / jump target)
//   valP   in  64  fall-through PC
//   valM   in  64  return address read from memory
//   new_pc out 64  PC of the next instruction
module pc_select
    import seq_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    output logic [63:0] new_pc
);

    always_comb begin
        new_pc = valP;
        case (icode)
            ICALL:   new_pc = valC;
            IJXX:    new_pc = cnd ? valC : valP;
            IRET:    new_pc = valM;
            default: new_pc = valP;
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// seq_controller: stage sequencer for the SEQ Y-86 processor.
// Steps fetch/decode/execute/memory/write-back/PC-update one stage per
// clock, owns the architectural PC and status code, and stops the machine
// on halt, invalid instruction, fetch address fault, data memory fault or
// a data memory timeout.
//   clk, rst                 clock, async active-high reset
//   run                      start request (IDLE only)
//   icode, cnd, valC, valP,  datapath values used for the next-PC decision
//   valM
//   halt, instruct_err,      fetch-stage fault flags (FETCH only)
//   mem_err
//   dmem_ready, dmem_err     data memory handshake (MEMORY only)
//   PC                       architectural PC
//   en_*                     one-hot stage enables
//   stat                     status code (AOK/HLT/ADR/INS)
//   busy                     executing (not IDLE, not STOP)
//   retired, instr_count     retirement pulse and counter
module seq_controller
    import seq_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    input  logic        halt,
    input  logic        instruct_err,
    input  logic        mem_err,
    input  logic        dmem_ready,
    input  logic        dmem_err,
    output logic [63:0] PC,
    output logic        en_fetch,
    output logic        en_decode,
    output logic        en_execute,
    output logic        en_memory,
    output logic        en_writeback,
    output logic        en_pc,
    output logic [2:0]  stat,
    output logic        busy,
    output logic        retired,
    output logic [31:0] instr_count
);

    // Wait-counter value seen on the last permitted MEMORY cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_next;
    logic [2:0]  stat_q, stat_next;
    logic [63:0] pc_q;
    logic [63:0] new_pc;
    logic [7:0]  wait_cnt;
    logic [31:0] count_q;

    pc_select u_pc_select (
        .icode  (icode),
        .cnd    (cnd),
        .valC   (valC),
        .valP   (valP),
        .valM   (valM),
        .new_pc (new_pc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            stat_q <= STAT_AOK;
        end else begin
            state  <= state_next;
            stat_q <= stat_next;
        end
    end

    // Next-state and status decision
    always_comb begin
        state_next = state;
        stat_next  = stat_q;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                // Fixed priority: address fault, then bad icode, then halt.
                if (mem_err) begin
                    state_next = S_STOP;
                    stat_next  = STAT_ADR;
                end else if (instruct_err) begin
                    state_next = S_STOP;
                    stat_next  = STAT_INS;
                end else if (halt) begin
                    state_next = S_STOP;
                    stat_next  = STAT_HLT;
                end else begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_MEMORY;
            S_MEMORY: begin
                // Ready on the final permitted cycle beats the timeout.
                if (dmem_ready) begin
                    if (dmem_err) begin
                        state_next = S_STOP;
                        stat_next  = STAT_ADR;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_STOP;
                    stat_next  = STAT_ADR;
                end
            end
            S_WRITEBACK: state_next = S_PCUPD;
            S_PCUPD:     state_next = S_FETCH;
            S_STOP:      state_next = S_STOP;
            default:     state_next = S_IDLE;
        endcase
    end

    // Wait counter: held at zero outside MEMORY so every entry starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (state != S_MEMORY) begin
            wait_cnt <= 8'd0;
        end else if (!dmem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // PC and retirement counter only change on the PC-update stage, so a
    // faulting or halting instruction leaves both untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else if (state == S_PCUPD) begin
            pc_q    <= new_pc;
            count_q <= count_q + 32'd1;
        end
    end

    // Outputs decoded from the state register so reset clears them at once.
    assign en_fetch     = (state == S_FETCH);
    assign en_decode    = (state == S_DECODE);
    assign en_execute   = (state == S_EXECUTE);
    assign en_memory    = (state == S_MEMORY);
    assign en_writeback = (state == S_WRITEBACK);
    assign en_pc        = (state == S_PCUPD);
    assign busy         = (state != S_IDLE) && (state != S_STOP);
    assign retired      = (state == S_PCUPD);

    assign PC          = pc_q;
    assign stat        = stat_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller with a scoreboard queue of expected
// post-instruction architectural state.
module tb_seq_controller;

    localparam logic [63:0] RST_PC = 64'h100;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        rst, run, cnd, halt, instruct_err, mem_err, dmem_ready, dmem_err;
    logic [3:0]  icode;
    logic [63:0] valC, valP, valM, PC;
    logic        en_fetch, en_decode, en_execute, en_memory, en_writeback, en_pc;
    logic [2:0]  stat;
    logic        busy, retired;
    logic [31:0] instr_count;

    seq_controller #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .run(run), .icode(icode), .cnd(cnd),
        .valC(valC), .valP(valP), .valM(valM), .halt(halt),
        .instruct_err(instruct_err), .mem_err(mem_err),
        .dmem_ready(dmem_ready), .dmem_err(dmem_err), .PC(PC),
        .en_fetch(en_fetch), .en_decode(en_decode), .en_execute(en_execute),
        .en_memory(en_memory), .en_writeback(en_writeback), .en_pc(en_pc),
        .stat(stat), .busy(busy), .retired(retired), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] cnt;
        logic [2:0]  st;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] en_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    wire [5:0] en_vec = {en_pc, en_writeback, en_memory, en_execute, en_decode, en_fetch};

    function automatic logic [63:0] ref_pc(input logic [3:0] ic, input logic c,
                                           input logic [63:0] vc, vp, vm);
        if (ic == 4'h8) return vc;
        if (ic == 4'h7) return c ? vc : vp;
        if (ic == 4'h9) return vm;
        return vp;
    endfunction

    task automatic do_reset;
        rst = 1'b1; run = 1'b0; icode = 4'h1; cnd = 1'b0;
        valC = '0; valP = '0; valM = '0;
        halt = 1'b0; instruct_err = 1'b0; mem_err = 1'b0;
        dmem_ready = 1'b0; dmem_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse run in IDLE; returns one step after the edge, in FETCH.
    task automatic start;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic set_instr(input logic [3:0] ic, input logic c,
                             input logic [63:0] vc, vp, vm,
                             input logic me, ie, h, de);
        icode = ic; cnd = c; valC = vc; valP = vp; valM = vm;
        mem_err = me; instruct_err = ie; halt = h; dmem_err = de;
        dmem_ready = 1'b0;
    endtask

    // Advance one instruction from FETCH until the next FETCH or a stop.
    // dmem_ready rises on MEMORY cycle mem_wait+1.
    task automatic exec(input int mem_wait, output int cyc, output int mcyc,
                        output bit tmo);
        cyc = 0; mcyc = 0; tmo = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (en_memory) begin
                mcyc++;
                dmem_ready = (mcyc > mem_wait);
            end
            if (en_fetch || !busy) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; #1;
        n_tests++;
        if (PC !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", PC, RST_PC); end
        n_tests++;
        if (stat !== 3'd1) begin n_fail++; $display("FAIL reset_stat got %0d want 1", stat); end
        n_tests++;
        if ({en_vec, busy, retired} !== 8'd0) begin n_fail++; $display("FAIL reset_outs got %b want 0", {en_vec, busy, retired}); end
        n_tests++;
        if (instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", instr_count); end
        do_reset();
        repeat (3) @(posedge clk); #1;
        n_tests++;
        if (en_vec !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold en %b busy %b want 0 0", en_vec, busy); end
    endtask

    task automatic test_nop;
        logic [5:0] e;
        do_reset();
        set_instr(4'h1, 1'b0, 64'h0, 64'h1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        for (int k = 0; k < 6; k++) en_q.push_back(6'(1 << k));
        start();
        for (int k = 0; k < 6; k++) begin
            e = en_q.pop_front();
            n_tests++;
            if (en_vec !== e) begin n_fail++; $display("FAIL nop_enable cyc %0d got %b want %b", k + 1, en_vec, e); end
            n_tests++;
            if (retired !== (k == 5)) begin n_fail++; $display("FAIL nop_retired cyc %0d got %b want %b", k + 1, retired, k == 5); end
            @(posedge clk); #1;
        end
        n_tests++;
        if (en_fetch !== 1'b1 || PC !== 64'h1) begin n_fail++; $display("FAIL nop_pc en_fetch %b pc %h want 1 1", en_fetch, PC); end
        n_tests++;
        if (instr_count !== 32'd1) begin n_fail++; $display("FAIL nop_count got %0d want 1", instr_count); end
    endtask

    task automatic test_jxx;
        int cyc, mcyc; bit tmo; exp_t x;
        for (int c = 1; c >= 0; c--) begin
            set_instr(4'h7, c[0], 64'h40, 64'h9, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            sb.push_back('{c ? 64'h40 : 64'h9, instr_count + 32'd1, 3'd1});
            exec(0, cyc, mcyc, tmo);
            x = sb.pop_front();
            n_tests++;
            if (tmo || PC !== x.pc || instr_count !== x.cnt) begin
                n_fail++; $display("FAIL jxx_cnd%0d pc %h cnt %0d tmo %0d want pc %h cnt %0d", c, PC, instr_count, tmo, x.pc, x.cnt);
            end
            n_tests++;
            if (cyc !== 6) begin n_fail++; $display("FAIL jxx_latency got %0d want 6", cyc); end
        end
    endtask

    task automatic test_call_ret;
        int cyc, mcyc; bit tmo; exp_t x;
        do_reset();
        start();
        set_instr(4'h8, 1'b0, 64'h20, 64'h109, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back('{64'h20, 32'd1, 3'd1});
        exec(0, cyc, mcyc, tmo);
        x = sb.pop_front();
        n_tests++;
        if (tmo || PC !== x.pc || instr_count !== x.cnt) begin n_fail++; $display("FAIL call pc %h cnt %0d want %h %0d", PC, instr_count, x.pc, x.cnt); end
        set_instr(4'h9, 1'b0, 64'h0, 64'h21, 64'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back('{64'h0A, 32'd2, 3'd1});
        exec(0, cyc, mcyc, tmo);
        x = sb.pop_front();
        n_tests++;
        if (tmo || PC !== x.pc || instr_count !== x.cnt) begin n_fail++; $display("FAIL ret pc %h cnt %0d want %h %0d", PC, instr_count, x.pc, x.cnt); end
    endtask

    task automatic test_mem_wait;
        int cyc, mcyc; bit tmo;
        // Continues from PC=0x0A: ready only on the final permitted cycle.
        set_instr(4'h5, 1'b0, 64'h0, 64'h0B, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        exec(TMO - 1, cyc, mcyc, tmo);
        n_tests++;
        if (tmo || stat !== 3'd1 || PC !== 64'h0B) begin n_fail++; $display("FAIL mem_ready_last stat %0d pc %h want 1 0b", stat, PC); end
        n_tests++;
        if (mcyc !== TMO || cyc !== 6 + TMO - 1) begin n_fail++; $display("FAIL mem_ready_cycles mem %0d total %0d want %0d %0d", mcyc, cyc, TMO, 6 + TMO - 1); end
    endtask

    task automatic test_dmem_err;
        int cyc, mcyc; bit tmo;
        set_instr(4'h4, 1'b0, 64'h0, 64'h33, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        exec(0, cyc, mcyc, tmo);
        n_tests++;
        if (tmo || stat !== 3'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL dmem_err stat %0d busy %b want 3 0", stat, busy); end
        n_tests++;
        if (PC !== 64'h0B || instr_count !== 32'd3 || cyc !== 4) begin n_fail++; $display("FAIL dmem_err_hold pc %h cnt %0d cyc %0d want 0b 3 4", PC, instr_count, cyc); end
    endtask

    task automatic test_timeout;
        int cyc, mcyc; bit tmo;
        do_reset();
        start();
        set_instr(4'h5, 1'b0, 64'h0, 64'h200, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        exec(1000, cyc, mcyc, tmo);
        n_tests++;
        if (tmo || stat !== 3'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout stat %0d busy %b want 3 0", stat, busy); end
        n_tests++;
        if (mcyc !== TMO || cyc !== 3 + TMO) begin n_fail++; $display("FAIL timeout_cycles mem %0d total %0d want %0d %0d", mcyc, cyc, TMO, 3 + TMO); end
        n_tests++;
        if (PC !== RST_PC || instr_count !== 32'd0) begin n_fail++; $display("FAIL timeout_hold pc %h cnt %0d want %h 0", PC, instr_count, RST_PC); end
    endtask

    task automatic test_fetch_fault;
        int cyc, mcyc; bit tmo;
        logic [2:0] flags [3] = '{3'b111, 3'b011, 3'b001};
        logic [2:0] want  [3] = '{3'd3, 3'd4, 3'd2};
        for (int t = 0; t < 3; t++) begin
            do_reset();
            start();
            set_instr(4'h1, 1'b0, 64'h0, 64'h5, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            exec(0, cyc, mcyc, tmo);
            set_instr(4'h0, 1'b0, 64'h0, 64'h6, 64'h0, flags[t][2], flags[t][1], flags[t][0], 1'b0);
            exec(0, cyc, mcyc, tmo);
            n_tests++;
            if (tmo || stat !== want[t] || busy !== 1'b0 || cyc !== 1) begin
                n_fail++; $display("FAIL fetch_fault%0d stat %0d busy %b cyc %0d want %0d 0 1", t, stat, busy, cyc, want[t]);
            end
            n_tests++;
            if (PC !== 64'h5 || instr_count !== 32'd1) begin n_fail++; $display("FAIL fetch_fault_hold%0d pc %h cnt %0d want 5 1", t, PC, instr_count); end
            run = 1'b1;
            repeat (3) @(posedge clk); #1;
            run = 1'b0;
            n_tests++;
            if (en_vec !== 6'd0 || busy !== 1'b0 || stat !== want[t]) begin
                n_fail++; $display("FAIL stop_sticky%0d en %b busy %b stat %0d", t, en_vec, busy, stat);
            end
        end
    endtask

    task automatic test_reset_mid;
        int cyc, mcyc; bit tmo, seen;
        do_reset();
        start();
        set_instr(4'h1, 1'b0, 64'h0, 64'h55, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        exec(0, cyc, mcyc, tmo);
        set_instr(4'h1, 1'b0, 64'h0, 64'h66, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = en_execute;
        end
        n_tests++;
        if (!seen || PC !== 64'h55) begin n_fail++; $display("FAIL reset_mid_setup seen %b pc %h want 1 55", seen, PC); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (PC !== RST_PC || stat !== 3'd1 || en_vec !== 6'd0 || busy !== 1'b0 || instr_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid pc %h stat %0d en %b busy %b cnt %0d", PC, stat, en_vec, busy, instr_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc, mcyc; bit tmo; exp_t x;
        logic [3:0] ic; logic c; logic [63:0] vc, vp, vm; int w;
        do_reset();
        start();
        for (int n = 0; n < 10; n++) begin
            ic = 4'($urandom_range(1, 11));
            if (n < 3) ic = 4'(7 + n);
            c  = 1'($urandom_range(0, 1));
            vc = {$urandom, $urandom}; vp = {$urandom, $urandom}; vm = {$urandom, $urandom};
            w  = $urandom_range(0, 3);
            set_instr(ic, c, vc, vp, vm, 1'b0, 1'b0, 1'b0, 1'b0);
            sb.push_back('{ref_pc(ic, c, vc, vp, vm), 32'(n + 1), 3'd1});
            exec(w, cyc, mcyc, tmo);
            x = sb.pop_front();
            n_tests++;
            if (tmo || PC !== x.pc || instr_count !== x.cnt || stat !== x.st) begin
                n_fail++; $display("FAIL b2b%0d ic %0d pc %h cnt %0d want %h %0d", n, ic, PC, instr_count, x.pc, x.cnt);
            end
            n_tests++;
            if (cyc !== 6 + w) begin n_fail++; $display("FAIL b2b_latency%0d got %0d want %0d", n, cyc, 6 + w); end
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_jxx();
        test_call_ret();
        test_mem_wait();
        test_dmem_err();
        test_timeout();
        test_fetch_fault();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
# seq_controller

Sequencing controller for the single-cycle-per-stage SEQ Y-86 processor. It steps the datapath through fetch, decode, execute, memory, write-back and PC-update, one stage per clock. It owns the architectural PC register and the processor status code. It stops the machine on halt, invalid instruction, or address/memory fault, including a memory-stage timeout.

## Interface
- RESET_PC, default 64'd0: PC value loaded on reset.
- MEM_TIMEOUT, default 16: maximum cycles spent in MEMORY waiting for dmem_ready; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  start request, sampled only in IDLE.
- icode  in  4  instruction code from fetch.
- cnd  in  1  condition result from execute.
- valC  in  64  constant word from fetch.
- valP  in  64  fall-through PC from fetch.
- valM  in  64  word read by memory stage.
- halt  in  1  fetch decoded halt.
- instruct_err  in  1  fetch decoded an invalid icode.
- mem_err  in  1  fetch address out of range.
- dmem_ready  in  1  memory stage access complete.
- dmem_err  in  1  memory stage address fault, qualified by dmem_ready.
- PC  out  64  current architectural PC.
- en_fetch, en_decode, en_execute, en_memory, en_writeback, en_pc  out  1 each  one-hot stage enables.
- stat  out  3  status: AOK=1, HLT=2, ADR=3, INS=4.
- busy  out  1  high in any state except IDLE and STOP.
- retired  out  1  one-cycle pulse per completed instruction.
- instr_count  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP.
- Stage enables are decoded from the state register.
  - Each enable is high only in its state. en_pc is high in PCUPD.
  - All enables are 0 in IDLE and STOP.
- Transitions:
  - IDLE: stays until run=1, then goes to FETCH.
  - FETCH: fault priority is mem_err, then instruct_err, then halt. On a fault, go to STOP and set stat to ADR, INS or HLT respectively. Otherwise go to DECODE.
  - DECODE goes to EXECUTE; EXECUTE goes to MEMORY; each takes one cycle.
  - MEMORY: waits for dmem_ready=1.
    - dmem_ready=1 with dmem_err=1: go to STOP, stat=ADR.
    - dmem_ready=1 with dmem_err=0: go to WRITEBACK.
    - Wait counter reaches MEM_TIMEOUT without ready: go to STOP, stat=ADR.
  - WRITEBACK goes to PCUPD.
  - PCUPD: loads newPC into PC, pulses retired, increments instr_count, then goes to FETCH.
  - STOP: terminal. Holds PC, stat and instr_count. run is ignored; only rst exits.
- newPC selection:
  - icode 8 (call): valC.
  - icode 7 (jxx): valC if cnd=1, else valP.
  - icode 9 (ret): valM.
  - All other icodes: valP.
- Arithmetic and width rules:
  - PC is 64-bit with no range check; range faults come from mem_err.
  - instr_count wraps from 2^32-1 to 0.
  - The wait counter is 8-bit and clears on entry to MEMORY.
- Retirement: halt and faulting instructions do not retire. PC remains at the faulting instruction.

## Timing
- Reset values: state=IDLE, PC=RESET_PC, stat=AOK, all enables 0, busy 0, retired 0, instr_count 0, wait counter 0.
- Reset mid-instruction aborts immediately, asynchronously. No partial PC update occurs.
- Cycle after run is sampled in IDLE: en_fetch=1.
- Latency with zero memory wait (dmem_ready=1 on the first MEMORY cycle):
  - 6 cycles per instruction.
  - retired pulses every 6th cycle.
  - The new PC is visible in the cycle where en_fetch is high.
- Each MEMORY wait cycle adds one cycle of latency.
- Timeout: ready absent in MEMORY cycles 1..MEM_TIMEOUT, so MEMORY occupies MEM_TIMEOUT cycles. STOP is entered on the following edge.
- Simultaneous events:
  - dmem_ready arriving on the timeout cycle wins over the timeout.
  - Multiple fetch flags: the fixed priority above applies.
- Inputs are sampled only in their owning state; they are don't-care elsewhere.

## Structure
- Package seq_pkg:
  - icode constants IHALT..IPOPQ (0..B).
  - stat codes AOK/HLT/ADR/INS.
  - state enum.
- Sub-module pc_select: combinational newPC mux with inputs icode, cnd, valC, valP, valM.
- Top level holds the FSM, PC, stat, wait counter and instr_count.

## Test plan
- Reset, then run=1, then nop (icode 1, valP=1) → en_fetch..en_pc each high for one cycle in order; PC=1 on cycle 7; instr_count=1.
- jxx with icode 7, valC=0x40, valP=9: cnd=1 gives PC=0x40; cnd=0 gives PC=9.
- call (valC=0x20) then ret (valM=0x0A) → PC=0x20, then PC=0x0A; instr_count=2.
- halt and instruct_err both high in FETCH → STOP with stat=INS; PC unchanged; busy=0; a later run=1 has no effect.
- MEMORY with dmem_ready low for 16 cycles (MEM_TIMEOUT=16) → stat=ADR.
- MEMORY with ready on cycle 16 → no fault; WRITEBACK follows.
- Assert rst during EXECUTE → IDLE immediately; PC=RESET_PC; stat=AOK; all enables 0 before the next edge.
